priv_access_initiator: RTL and testbench

- Requester-side bridge that drives the two-port (user/admin) shared-memory responder.
- Accepts tagged commands (read/write, privilege, address, data) into a small FIFO and issues each one on the port matching its privilege, one at a time.
- Returns the read data, an error flag and the tag on a valid/ready response channel.
- Blocks user-privileged commands that target the admin region before they reach memory, so the deputy never forwards a user request with admin authority.

---
 rtl/priv_access_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 43 ++++
 rtl/priv_access_initiator.sv | 125 ++++++++++++
 tb/tb_priv_access_initiator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/priv_access_pkg.sv
// Shared types for the privileged-access initiator: FSM states, command/response records.
package priv_access_pkg;

  // Struct field widths; the top-level width parameters must match these.
  localparam int CMD_DATA_W = 32;
  localparam int CMD_ADDR_W = 8;
  localparam int CMD_TAG_W  = 4;

  localparam logic PRIV_USER  = 1'b0;
  localparam logic PRIV_ADMIN = 1'b1;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic                  write;
    logic                  priv;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [CMD_DATA_W-1:0] data;
    logic                  err;
    logic [CMD_TAG_W-1:0]  tag;
  } rsp_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [PW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din;
  end

  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty = (wr_q == rd_q);
  assign dout  = mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/priv_access_initiator.sv
// Requester bridge: queues tagged commands, screens user access to the admin region,
// and issues each legal command on the port matching its privilege, one at a time.
module priv_access_initiator
  import priv_access_pkg::*;
#(
  parameter int                  DATA_WIDTH = CMD_DATA_W,
  parameter int                  ADDR_WIDTH = CMD_ADDR_W,
  parameter int                  TAG_WIDTH  = CMD_TAG_W,
  parameter int                  CMD_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] ADMIN_BASE = 8'hC0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_priv,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  user_req,
  output logic                  user_we,
  output logic [ADDR_WIDTH-1:0] user_addr,
  output logic [DATA_WIDTH-1:0] user_wdata,
  input  logic [DATA_WIDTH-1:0] user_rdata,
  output logic                  admin_req,
  output logic                  admin_we,
  output logic [ADDR_WIDTH-1:0] admin_addr,
  output logic [DATA_WIDTH-1:0] admin_wdata,
  input  logic [DATA_WIDTH-1:0] admin_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [TAG_WIDTH-1:0]  rsp_tag
);

  state_e state_q, state_d;
  cmd_t   cmd_in, head, hold_q, hold_d;
  rsp_t   rsp_q, rsp_d;
  logic   full, empty, pop, violation, issue;

  assign cmd_in = '{write: cmd_write, priv: cmd_priv, addr: cmd_addr,
                    wdata: cmd_wdata, tag: cmd_tag};
  assign cmd_ready = !full;

  cmd_fifo #(.DEPTH(CMD_DEPTH), .T(cmd_t)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (cmd_valid),
    .pop    (pop),
    .din    (cmd_in),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  // A user command may never reach the admin region, on either port.
  assign violation = (hold_q.priv == PRIV_USER) && (hold_q.addr >= ADMIN_BASE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rsp_d   = rsp_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = head;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (violation) begin
          rsp_d   = '{data: '0, err: 1'b1, tag: hold_q.tag};
          state_d = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_d.data = hold_q.write ? '0 :
                     (hold_q.priv == PRIV_ADMIN) ? admin_rdata : user_rdata;
        rsp_d.err  = 1'b0;
        rsp_d.tag  = hold_q.tag;
        state_d    = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue = (state_q == ISSUE);

  // Port fields are zeroed whenever their strobe is low.
  assign user_req    = issue && (hold_q.priv == PRIV_USER);
  assign user_we     = user_req && hold_q.write;
  assign user_addr   = user_req ? hold_q.addr  : '0;
  assign user_wdata  = user_req ? hold_q.wdata : '0;

  assign admin_req   = issue && (hold_q.priv == PRIV_ADMIN);
  assign admin_we    = admin_req && hold_q.write;
  assign admin_addr  = admin_req ? hold_q.addr  : '0;
  assign admin_wdata = admin_req ? hold_q.wdata : '0;

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;
  assign rsp_tag   = rsp_q.tag;

endmodule

// File: tb/tb_priv_access_initiator.sv
// Directed bench for priv_access_initiator with a shared-memory responder model.
module tb_priv_access_initiator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_priv;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_tag;
  logic        user_req, user_we, admin_req, admin_we;
  logic [7:0]  user_addr, admin_addr;
  logic [31:0] user_wdata, admin_wdata, user_rdata, admin_rdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  int errors = 0;
  int checks = 0;
  int ucnt = 0;
  int acnt = 0;
  int u0, a0, u1, a1;
  logic both_seen = 1'b0;
  logic mem_init = 1'b0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  priv_access_initiator dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_priv(cmd_priv), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag),
    .user_req(user_req), .user_we(user_we), .user_addr(user_addr),
    .user_wdata(user_wdata), .user_rdata(user_rdata),
    .admin_req(admin_req), .admin_we(admin_we), .admin_addr(admin_addr),
    .admin_wdata(admin_wdata), .admin_rdata(admin_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  // Responder: one shared memory, read data returned the cycle after the strobe.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | 32'(i);
      mem[8'h10] <= 32'h1234_5678;
      mem_init <= 1'b1;
    end
    if (user_req) begin
      ucnt <= ucnt + 1;
      user_rdata <= mem[user_addr];
      if (user_we) mem[user_addr] <= user_wdata;
    end
    if (admin_req) begin
      acnt <= acnt + 1;
      admin_rdata <= mem[admin_addr];
      if (admin_we) mem[admin_addr] <= admin_wdata;
    end
    if (user_req && admin_req) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic p, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] t);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_priv = p;
    cmd_addr = a; cmd_wdata = d; cmd_tag = t;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("push_accept", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [31:0] d, input logic e, input logic [3:0] t);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("rsp_arrive", {63'd0, rsp_valid}, 64'd1);
    chk("rsp_data", {32'd0, rsp_data}, {32'd0, d});
    chk("rsp_err_tag", {59'd0, rsp_err, rsp_tag}, {59'd0, e, t});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_priv = 0; cmd_addr = 0;
    cmd_wdata = 0; cmd_tag = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready_valid", {62'd0, cmd_ready, rsp_valid}, 64'h2);
    chk("reset_ports", {38'd0, user_req, admin_req, user_we, admin_we, user_addr, admin_addr,
        rsp_err, rsp_tag}, 64'd0);
    chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
    reset_n = 1'b1;

    // Reset with three commands in flight / queued
    push(1'b0, 1'b0, 8'h10, 32'h0, 4'hA);
    push(1'b0, 1'b1, 8'h11, 32'h0, 4'hB);
    push(1'b1, 1'b0, 8'h12, 32'h5, 4'hC);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_outs", {60'd0, cmd_ready, rsp_valid, user_req, admin_req}, 64'h8);
    reset_n = 1'b1;
    u0 = ucnt; a0 = acnt;
    repeat (10) @(negedge clk);
    chk("midrst_no_strobe", {32'(ucnt - u0), 32'(acnt - a0)}, 64'd0);
    chk("midrst_idle", {62'd0, cmd_ready, rsp_valid}, 64'h2);

    // Admin write then admin read of the same location
    u0 = ucnt; a0 = acnt;
    push(1'b1, 1'b1, 8'hC4, 32'hDEAD_BEEF, 4'd1);
    push(1'b0, 1'b1, 8'hC4, 32'h0, 4'd2);
    get_rsp(32'h0, 1'b0, 4'd1);
    get_rsp(32'hDEAD_BEEF, 1'b0, 4'd2);
    chk("admin_strobes", {32'(ucnt - u0), 32'(acnt - a0)}, {32'd0, 32'd2});

    // User read: 4-cycle latency, user port only
    u0 = ucnt; a0 = acnt;
    push(1'b0, 1'b0, 8'h10, 32'h0, 4'd3);
    repeat (3) @(negedge clk);
    chk("user_issue", {46'd0, user_req, admin_req, user_we, user_addr, 7'd0},
        {46'd0, 1'b1, 1'b0, 1'b0, 8'h10, 7'd0});
    @(negedge clk);
    chk("lat_not_yet", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("lat_4cyc", {63'd0, rsp_valid}, 64'd1);
    get_rsp(32'h1234_5678, 1'b0, 4'd3);
    chk("user_strobes", {32'(ucnt - u0), 32'(acnt - a0)}, {32'd1, 32'd0});

    // Admin-region boundary for user commands
    u0 = ucnt; a0 = acnt;
    push(1'b1, 1'b0, 8'hC0, 32'h1111_1111, 4'd4);
    push(1'b1, 1'b0, 8'hFF, 32'h2222_2222, 4'd5);
    push(1'b1, 1'b0, 8'hBF, 32'hA5A5_A5A5, 4'd6);
    get_rsp(32'h0, 1'b1, 4'd4);
    get_rsp(32'h0, 1'b1, 4'd5);
    get_rsp(32'h0, 1'b0, 4'd6);
    chk("bound_strobes", {32'(ucnt - u0), 32'(acnt - a0)}, {32'd1, 32'd0});
    chk("bound_mem_bf", {32'd0, mem[8'hBF]}, {32'd0, 32'hA5A5_A5A5});
    chk("bound_mem_c0", {32'd0, mem[8'hC0]}, {32'd0, 32'h1000_00C0});
    chk("bound_mem_ff", {32'd0, mem[8'hFF]}, {32'd0, 32'h1000_00FF});

    // FIFO fill under back-pressure, then response stall
    u0 = ucnt; a0 = acnt;
    push(1'b0, 1'b0, 8'h20, 32'h0, 4'd7);
    push(1'b0, 1'b1, 8'h21, 32'h0, 4'd8);
    push(1'b1, 1'b0, 8'hC8, 32'h33, 4'd9);
    push(1'b0, 1'b0, 8'h22, 32'h0, 4'd10);
    push(1'b1, 1'b1, 8'h30, 32'h77, 4'd11);
    @(negedge clk);
    chk("full_ready_low", {63'd0, cmd_ready}, 64'd0);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    end
    u1 = ucnt; a1 = acnt;
    repeat (10) begin
      @(negedge clk);
      chk("stall_rsp", {27'd0, rsp_valid, rsp_data, rsp_err, rsp_tag},
          {27'd0, 1'b1, 32'h1000_0020, 1'b0, 4'd7});
    end
    chk("stall_no_strobe", {32'(ucnt - u1), 32'(acnt - a1)}, 64'd0);
    chk("stall_first_only", {32'(ucnt - u0), 32'(acnt - a0)}, {32'd1, 32'd0});
    get_rsp(32'h1000_0020, 1'b0, 4'd7);
    get_rsp(32'h1000_0021, 1'b0, 4'd8);
    get_rsp(32'h0, 1'b1, 4'd9);
    get_rsp(32'h1000_0022, 1'b0, 4'd10);
    get_rsp(32'h0, 1'b0, 4'd11);
    chk("drain_strobes", {32'(ucnt - u0), 32'(acnt - a0)}, {32'd2, 32'd2});
    chk("drain_mem_30", {32'd0, mem[8'h30]}, {32'd0, 32'h77});

    repeat (2) @(negedge clk);
    chk("idle_ports", {62'd0, cmd_ready, rsp_valid}, 64'h2);
    chk("idle_port_fields", {user_addr, admin_addr, user_wdata ^ admin_wdata, 16'd0}, 64'd0);
    chk("never_both_req", {63'd0, both_seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
